// File: rtl/uart_responder_pkg.sv
`default_nettype none
// ============================================================================
// Module   : uart_responder_pkg
// Brief    : Shared word/size definitions and byte-lane helpers for the
//            UART responder.
// Revision : 1.0 - initial release
// ============================================================================
package uart_responder_pkg;

    localparam int LEN_WORD = 32;
    localparam int BYTE_W   = 8;
    localparam int SIZE_W   = 2;

    // uart_size carries (byte count - 1)
    typedef enum logic [SIZE_W-1:0] {
        SZ_1B = 2'd0,
        SZ_2B = 2'd1,
        SZ_3B = 2'd2,
        SZ_4B = 2'd3
    } uart_size_e;

    function automatic logic [BYTE_W-1:0] get_byte(
        input logic [LEN_WORD-1:0] word,
        input logic [SIZE_W-1:0]   idx
    );
        return word[{idx, 3'b000} +: BYTE_W];
    endfunction

    function automatic logic [LEN_WORD-1:0] place_byte(
        input logic [LEN_WORD-1:0] word,
        input logic [BYTE_W-1:0]   b,
        input logic [SIZE_W-1:0]   idx
    );
        return word | (LEN_WORD'(b) << {idx, 3'b000});
    endfunction

endpackage : uart_responder_pkg
`default_nettype wire

// File: rtl/byte_fifo.sv
`default_nettype none
// ============================================================================
// Module   : byte_fifo
// Brief    : Synchronous FIFO with registered pointers; written data becomes
//            visible one cycle after the push (no bypass).
// Revision : 1.0 - initial release
// ============================================================================
module byte_fifo #(
    parameter int DEPTH = 16,
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW:0]      r_wr_ptr;
    logic [AW:0]      r_rd_ptr;
    logic             w_wr_en;
    logic             w_rd_en;

    // Extra MSB separates the full case from the empty case at equal indices
    assign empty   = (r_wr_ptr == r_rd_ptr);
    assign full    = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                     (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
    assign w_rd_en = pop & ~empty;
    assign w_wr_en = push & (~full | w_rd_en);
    assign dout    = r_mem[r_rd_ptr[AW-1:0]];

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_wr_en) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_rd_en) r_rd_ptr <= r_rd_ptr + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (w_wr_en) r_mem[r_wr_ptr[AW-1:0]] <= din;
    end

endmodule : byte_fifo
`default_nettype wire

// File: rtl/uart_responder.sv
`default_nettype none
// ============================================================================
// Module   : uart_responder
// Brief    : Bridges core word requests to a byte-wide UART serializer
//            (transmit) and a buffered byte stream (receive).
// Revision : 1.0 - initial release
// ============================================================================
module uart_responder
    import uart_responder_pkg::*;
#(
    parameter int FIFO_DEPTH = 16
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                uart_order,
    input  logic                uart_write_flag,
    input  logic [SIZE_W-1:0]   uart_size,
    input  logic [LEN_WORD-1:0] uart_o_data,
    output logic [LEN_WORD-1:0] uart_i_data,
    output logic                uart_accepted,
    output logic                uart_accessed,
    output logic [BYTE_W-1:0]   tx_data,
    output logic                tx_valid,
    input  logic                tx_ready,
    input  logic [BYTE_W-1:0]   rx_data,
    input  logic                rx_valid,
    output logic                rx_overrun
);

    typedef enum logic [3:0] {
        ST_IDLE = 4'b0001,
        ST_TX   = 4'b0010,
        ST_RX   = 4'b0100,
        ST_DONE = 4'b1000
    } state_t;

    state_t              r_state;
    logic [SIZE_W-1:0]   r_size;
    logic [SIZE_W-1:0]   r_k;
    logic [LEN_WORD-1:0] r_odata;
    logic [LEN_WORD-1:0] r_rx_word;
    logic [LEN_WORD-1:0] r_idata;
    logic                r_accepted;
    logic                r_accessed;
    logic [BYTE_W-1:0]   r_tx_data;
    logic                r_tx_valid;
    logic                r_overrun;

    logic [BYTE_W-1:0]   w_fifo_dout;
    logic                w_fifo_full;
    logic                w_fifo_empty;
    logic                w_pop;
    logic                w_drop;
    logic                w_last;
    logic [LEN_WORD-1:0] w_rx_word;

    assign w_pop     = (r_state == ST_RX) & ~w_fifo_empty;
    assign w_drop    = rx_valid & w_fifo_full & ~w_pop;
    assign w_last    = (r_k == r_size);
    assign w_rx_word = place_byte(r_rx_word, w_fifo_dout, r_k);

    byte_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (BYTE_W)
    ) u_rx_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (rx_valid),
        .pop   (w_pop),
        .din   (rx_data),
        .dout  (w_fifo_dout),
        .full  (w_fifo_full),
        .empty (w_fifo_empty)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= ST_IDLE;
            r_size     <= '0;
            r_k        <= '0;
            r_odata    <= '0;
            r_rx_word  <= '0;
            r_idata    <= '0;
            r_accepted <= 1'b0;
            r_accessed <= 1'b0;
            r_tx_data  <= '0;
            r_tx_valid <= 1'b0;
            r_overrun  <= 1'b0;
        end else begin
            r_accepted <= 1'b0;
            r_accessed <= 1'b0;
            if (w_drop) r_overrun <= 1'b1;

            unique case (r_state)
                ST_IDLE: begin
                    if (uart_order) begin
                        r_size     <= uart_size;
                        r_odata    <= uart_o_data;
                        r_k        <= '0;
                        r_rx_word  <= '0;
                        r_accepted <= 1'b1;
                        if (uart_write_flag) begin
                            r_state    <= ST_TX;
                            r_tx_valid <= 1'b1;
                            r_tx_data  <= get_byte(uart_o_data, 2'd0);
                        end else begin
                            r_state <= ST_RX;
                        end
                    end
                end
                ST_TX: begin
                    if (r_tx_valid && tx_ready) begin
                        if (w_last) begin
                            r_state    <= ST_DONE;
                            r_tx_valid <= 1'b0;
                            r_tx_data  <= '0;
                            r_accessed <= 1'b1;
                        end else begin
                            r_k       <= r_k + 1'b1;
                            r_tx_data <= get_byte(r_odata, r_k + 1'b1);
                        end
                    end
                end
                ST_RX: begin
                    if (w_pop) begin
                        if (w_last) begin
                            r_state    <= ST_DONE;
                            r_idata    <= w_rx_word;
                            r_accessed <= 1'b1;
                        end else begin
                            r_rx_word <= w_rx_word;
                            r_k       <= r_k + 1'b1;
                        end
                    end
                end
                ST_DONE: begin
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign uart_i_data   = r_idata;
    assign uart_accepted = r_accepted;
    assign uart_accessed = r_accessed;
    assign tx_data       = r_tx_data;
    assign tx_valid      = r_tx_valid;
    assign rx_overrun    = r_overrun;

endmodule : uart_responder
`default_nettype wire

// File: tb/tb_uart_responder.sv
`default_nettype none
// ============================================================================
// Module   : tb_uart_responder
// Brief    : Directed scoreboard bench for uart_responder.
// Revision : 1.0 - initial release
// ============================================================================
module tb_uart_responder;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        uart_order = 1'b0;
    logic        uart_write_flag = 1'b0;
    logic [1:0]  uart_size = 2'd0;
    logic [31:0] uart_o_data = 32'h0;
    logic [31:0] uart_i_data;
    logic        uart_accepted;
    logic        uart_accessed;
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic        tx_ready = 1'b1;
    logic [7:0]  rx_data = 8'h0;
    logic        rx_valid = 1'b0;
    logic        rx_overrun;

    uart_responder #(.FIFO_DEPTH(16)) dut (
        .clk             (clk),
        .rst             (rst),
        .uart_order      (uart_order),
        .uart_write_flag (uart_write_flag),
        .uart_size       (uart_size),
        .uart_o_data     (uart_o_data),
        .uart_i_data     (uart_i_data),
        .uart_accepted   (uart_accepted),
        .uart_accessed   (uart_accessed),
        .tx_data         (tx_data),
        .tx_valid        (tx_valid),
        .tx_ready        (tx_ready),
        .rx_data         (rx_data),
        .rx_valid        (rx_valid),
        .rx_overrun      (rx_overrun)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit          is_rx;
        logic [31:0] data;
        int          lat;
    } exp_t;

    exp_t        exp_q[$];
    logic [7:0]  tx_q[$];
    logic [31:0] held_idata = 32'h0;
    int          cyc = 0;
    int          t_order = 0;
    int          n_chk = 0;
    int          n_fail = 0;
    int          done_cnt = 0;
    int          acc_cnt = 0;
    int          acc_exp = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: compares every DUT response against the scoreboard queues
    always @(negedge clk) begin
        if (!rst) begin
            if (uart_accepted) begin
                acc_cnt++;
                check("accept_latency", cyc - t_order, 1);
            end
            if (tx_valid && tx_ready) begin
                if (tx_q.size() == 0) check("unexpected_tx_byte", {24'h0, tx_data}, 32'hFFFF_FFFF);
                else check("tx_byte", {24'h0, tx_data}, {24'h0, tx_q.pop_front()});
            end
            if (uart_accessed) begin
                done_cnt++;
                if (exp_q.size() == 0) begin
                    check("unexpected_accessed", 32'h1, 32'h0);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    check(e.is_rx ? "rx_word" : "idata_held_on_tx", uart_i_data, e.data);
                    if (e.lat >= 0) check("accessed_latency", cyc - t_order, e.lat);
                    if (!e.is_rx) check("tx_valid_in_done", {31'h0, tx_valid}, 32'h0);
                end
            end
        end
    end

    task automatic do_order(input bit wf, input logic [1:0] sz, input logic [31:0] d,
                            input logic [31:0] exp_data, input int lat, input bit push_exp);
        @(posedge clk); #1;
        uart_order = 1'b1; uart_write_flag = wf; uart_size = sz; uart_o_data = d;
        t_order = cyc;
        acc_exp++;
        if (push_exp) begin
            exp_t e;
            e.is_rx = !wf;
            e.data  = wf ? held_idata : exp_data;
            e.lat   = lat;
            exp_q.push_back(e);
            if (!wf) held_idata = exp_data;
            else for (int i = 0; i <= int'(sz); i++) tx_q.push_back(d[8*i +: 8]);
        end
        @(posedge clk); #1;
        uart_order = 1'b0;
    endtask

    task automatic send_rx(input logic [7:0] b);
        @(posedge clk); #1;
        rx_valid = 1'b1; rx_data = b;
        @(posedge clk); #1;
        rx_valid = 1'b0;
    endtask

    task automatic wait_done(input int budget);
        int start;
        int i;
        start = done_cnt;
        i = 0;
        while (done_cnt == start && i < budget) begin
            @(posedge clk);
            i++;
        end
        check("accessed_seen", {31'h0, done_cnt != start}, 32'h1);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_i_data"},   uart_i_data, 32'h0);
        check({tag, "_accepted"}, {31'h0, uart_accepted}, 32'h0);
        check({tag, "_accessed"}, {31'h0, uart_accessed}, 32'h0);
        check({tag, "_tx_valid"}, {31'h0, tx_valid}, 32'h0);
        check({tag, "_tx_data"},  {24'h0, tx_data}, 32'h0);
        check({tag, "_overrun"},  {31'h0, rx_overrun}, 32'h0);
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check_reset_outputs("reset");

        // TX 4 bytes back-to-back
        tx_ready = 1'b1;
        do_order(1'b1, 2'd3, 32'h4433_2211, 32'h0, 5, 1'b1);
        wait_done(20);

        // TX 1 byte with serializer stalled for 5 cycles
        tx_ready = 1'b0;
        do_order(1'b1, 2'd0, 32'hAABB_CC11, 32'h0, 7, 1'b1);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("stall_tx_valid", {31'h0, tx_valid}, 32'h1);
            check("stall_tx_data", {24'h0, tx_data}, 32'h11);
        end
        @(posedge clk); #1 tx_ready = 1'b1;
        wait_done(20);

        // RX 2 bytes arriving after the request
        do_order(1'b0, 2'd1, 32'h0, 32'h0000_CDAB, -1, 1'b1);
        repeat (3) @(negedge clk);
        send_rx(8'hAB);
        @(posedge clk);
        send_rx(8'hCD);
        wait_done(20);

        // Second order while a TX is in progress must be ignored
        do_order(1'b1, 2'd2, 32'h00C0_B0A0, 32'h0, 4, 1'b1);
        uart_order = 1'b1; uart_write_flag = 1'b0; uart_size = 2'd3; uart_o_data = 32'hFFFF_FFFF;
        @(posedge clk); #1 uart_order = 1'b0;
        wait_done(20);
        check("accept_count", acc_cnt, acc_exp);

        // Fill FIFO past capacity, then read four bytes
        for (int i = 0; i < 17; i++) begin
            @(posedge clk); #1;
            rx_valid = 1'b1; rx_data = 8'(i);
            if (i == 16) check("overrun_at_full", {31'h0, rx_overrun}, 32'h0);
        end
        @(posedge clk); #1 rx_valid = 1'b0;
        check("overrun_set", {31'h0, rx_overrun}, 32'h1);
        do_order(1'b0, 2'd3, 32'h0, 32'h0302_0100, 5, 1'b1);
        wait_done(20);
        check("overrun_sticky", {31'h0, rx_overrun}, 32'h1);

        // Reset with traffic present; FIFO must come back empty
        @(posedge clk); #1;
        rst = 1'b1; rx_valid = 1'b1; rx_data = 8'h77;
        uart_order = 1'b1; uart_write_flag = 1'b0; uart_size = 2'd0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0; rx_valid = 1'b0; uart_order = 1'b0;
        held_idata = 32'h0;
        @(negedge clk);
        check_reset_outputs("reset2");
        do_order(1'b0, 2'd0, 32'h0, 32'h0000_005A, -1, 1'b1);
        repeat (4) @(negedge clk);
        send_rx(8'h5A);
        wait_done(20);

        // Reset in the middle of a 4-byte RX after one byte
        do_order(1'b0, 2'd3, 32'h0, 32'h0, -1, 1'b0);
        send_rx(8'h01);
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk); #1 rst = 1'b0;
        held_idata = 32'h0;
        @(negedge clk);
        check_reset_outputs("reset_mid_rx");
        repeat (6) @(posedge clk);

        check("scoreboard_empty", exp_q.size(), 0);
        check("tx_queue_empty", tx_q.size(), 0);
        check("final_accept_count", acc_cnt, acc_exp);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule : tb_uart_responder
`default_nettype wire

// File: doc/uart_responder.md
UART_RESPONDER -- requirements
Module: uart_responder

Interface
REQ-001 Parameter FIFO_DEPTH, default 16, RX byte FIFO depth; SHALL be a power of two, 2..256.
REQ-002 Ports SHALL be exactly:
- clk  in  1  sole clock, all logic on posedge
- rst  in  1  synchronous, active-high reset
- uart_order  in  1  one-cycle request pulse from core
- uart_write_flag  in  1  1 = transmit (output), 0 = receive (input)
- uart_size  in  2  byte count minus one (0..3 -> 1..4 bytes)
- uart_o_data  in  32  transmit word, byte 0 = bits[7:0]
- uart_i_data  out  32  received word, zero-extended above the received bytes
- uart_accepted  out  1  one-cycle pulse, request latched
- uart_accessed  out  1  one-cycle pulse, transfer complete
- tx_data  out  8  byte to serializer
- tx_valid  out  1  tx_data valid
- tx_ready  in  1  serializer accepts byte when tx_valid & tx_ready
- rx_data  in  8  byte from deserializer
- rx_valid  in  1  one-cycle pulse, rx_data valid
- rx_overrun  out  1  sticky, RX byte dropped on full FIFO

Function
REQ-003 FSM states SHALL be IDLE, TX, RX, DONE; one-hot encoding.
REQ-004 In IDLE, uart_order SHALL latch write_flag, size and o_data, pulse uart_accepted on the next cycle, and enter TX or RX on that same next cycle.
REQ-005 uart_order outside IDLE SHALL be ignored: no accept, no latch, no effect on the transfer in progress.
REQ-006 In TX, tx_data SHALL present byte k (k = 0 first, little-endian) with tx_valid=1; k SHALL advance only on tx_valid & tx_ready.
REQ-007 After the handshake of byte size, TX SHALL go to DONE; tx_valid SHALL be 0 in the DONE cycle.
REQ-008 In RX, one byte SHALL be popped per cycle while the FIFO is non-empty; byte k SHALL be placed in bits[8k+7:8k]; an empty FIFO SHALL stall RX indefinitely.
REQ-009 After pop of byte size, RX SHALL go to DONE; uart_i_data SHALL update in the same cycle uart_accessed is high.
REQ-010 DONE SHALL last exactly one cycle with uart_accessed=1, then return to IDLE.
REQ-011 uart_i_data SHALL hold its value until the next receive completes; transmits SHALL NOT alter it.
REQ-012 Minimum latency SHALL be: order at T, accepted at T+1; n-byte transfer with tx_ready=1 or FIFO holding >= n bytes -> accessed at T+n+1.
REQ-013 FIFO push on rx_valid SHALL occur when not full, or when full with a pop in the same cycle.
REQ-014 A push at full without a simultaneous pop SHALL drop the byte and set rx_overrun; rx_overrun SHALL clear only on reset.
REQ-015 The FIFO SHALL have no bypass: a byte pushed at cycle C SHALL be poppable no earlier than C+1.
REQ-016 FIFO pointers SHALL wrap modulo FIFO_DEPTH; full and empty SHALL be distinguished by an extra pointer bit.
REQ-017 rx_valid SHALL be accepted in every state, including TX and DONE.

Reset
REQ-018 With rst=1 at a clock edge: state IDLE; FIFO empty; uart_i_data=0; uart_accepted=0; uart_accessed=0; tx_valid=0; tx_data=0; rx_overrun=0.
REQ-019 Reset mid-transfer SHALL abort without uart_accessed; a byte mid-handshake SHALL be dropped; rx_valid and uart_order during reset SHALL be ignored.

Structure
REQ-020 The uart_size encoding and the LEN_WORD width SHALL come from the shared include header; FSM state codes SHALL be local to the module.
REQ-021 The RX FIFO SHALL be a sub-module named byte_fifo (push, pop, din, dout, full, empty).

Verification
REQ-022 The bench SHALL cover these directed scenarios:
- TX, size=3, o_data=0x44332211, tx_ready=1 -> tx_data 0x11,0x22,0x33,0x44 on consecutive cycles; accessed at T+5.
- TX, size=0, tx_ready low for 5 cycles -> tx_valid held with 0x11; one handshake; accessed the cycle after it.
- RX, size=1, FIFO empty, bytes 0xAB then 0xCD arrive later -> uart_i_data=0x0000CDAB at the accessed pulse.
- 17 rx_valid pulses with no read (depth 16) -> rx_overrun=1; a following 4-byte read returns the first four bytes.
- uart_order during TX -> no second accepted pulse; original transfer completes unchanged.
- rst asserted mid-RX after 1 of 4 bytes -> no accessed pulse; all outputs at reset values the next cycle.
